// File: rtl/framebuffer.sv
// framebuffer: pixel store with ready/valid raster scanout through a 2-entry skid buffer.
// Define FB_DOUBLE_BUFFER_EN to split storage into front/back buffers with deferred swap.
module framebuffer #(
   parameter int FB_WIDTH  = 400,
   parameter int FB_HEIGHT = 240
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [$clog2(FB_WIDTH):0]   fb_x,
   input  logic [$clog2(FB_HEIGHT):0]  fb_y,
   input  logic [15:0]                 fb_color,
   input  logic                        fb_write,
   input  logic                        frame_start,
   output logic [15:0]                 out_pixel,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_last,
   output logic                        frame_done,
   output logic                        scan_busy,
   input  logic                        ctrl_swap,
   output logic                        swap_pending,
   output logic                        front_sel
);
   localparam int NPIX = FB_WIDTH * FB_HEIGHT;
`ifdef FB_DOUBLE_BUFFER_EN
   localparam int NBUF = 2;
`else
   localparam int NBUF = 1;
`endif
   localparam int AW = $clog2(NPIX * NBUF);
   localparam int CW = $clog2(NPIX + 1);

   typedef enum logic {IDLE, SCAN} state_t;
   state_t state, state_nx;

   logic [15:0]   mem [NPIX*NBUF];
   logic [15:0]   rd_data;
   logic [CW-1:0] rd_cnt, rd_idx;
   logic [AW-1:0] wr_addr, rd_addr;
   logic          wr_en, rd_en, rd_pend, rd_last, rd_last_q, room;
   logic [16:0]   sk0, sk1;
   logic [1:0]    sk_cnt;
   logic          push, pop;

   assign wr_en   = fb_write && int'(fb_x) < FB_WIDTH && int'(fb_y) < FB_HEIGHT;
   assign wr_addr = AW'(int'(fb_y) * FB_WIDTH + int'(fb_x) + ((NBUF == 2 && !front_sel) ? NPIX : 0));
   assign rd_idx  = (state == IDLE) ? '0 : rd_cnt;
   assign rd_addr = AW'(int'(rd_idx) + (front_sel ? NPIX : 0));
   assign rd_last = rd_idx == CW'(NPIX - 1);

   assign push      = rd_pend;
   assign pop       = out_valid && out_ready;
   assign out_valid = sk_cnt != 2'd0;
   assign out_pixel = sk0[15:0];
   assign out_last  = out_valid && sk0[16];
   assign scan_busy = state == SCAN || frame_done;
   // a new read may issue only if its data is guaranteed a free skid slot one cycle later
   assign room = sk_cnt == 2'd0 || (sk_cnt == 2'd1 && !(rd_pend && !pop)) || (sk_cnt == 2'd2 && pop && !rd_pend);

   always_comb begin
      state_nx = (state == IDLE) ? (frame_start ? SCAN : IDLE) : ((pop && out_last) ? IDLE : SCAN);
      rd_en    = (state == IDLE) ? frame_start : (rd_cnt != CW'(NPIX) && room);
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= fb_color;
      if (rd_en) rd_data <= mem[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         rd_cnt     <= '0;
         rd_pend    <= 1'b0;
         rd_last_q  <= 1'b0;
         sk_cnt     <= 2'd0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nx;
         rd_cnt     <= rd_en ? rd_idx + CW'(1) : rd_cnt;
         rd_pend    <= rd_en;
         rd_last_q  <= rd_en && rd_last;
         sk_cnt     <= sk_cnt + 2'(push) - 2'(pop);
         frame_done <= pop && out_last;
      end
   end

   always_ff @(posedge clk) begin
      if (pop) sk0 <= (sk_cnt == 2'd2) ? sk1 : {rd_last_q, rd_data};
      else if (push && sk_cnt == 2'd0) sk0 <= {rd_last_q, rd_data};
      if (push && (sk_cnt == 2'd2 || (sk_cnt == 2'd1 && !pop))) sk1 <= {rd_last_q, rd_data};
   end

`ifdef FB_DOUBLE_BUFFER_EN
   logic do_swap;
   assign do_swap = swap_pending && state == IDLE && !frame_start;

   always_ff @(posedge clk) begin
      if (reset) begin
         swap_pending <= 1'b0;
         front_sel    <= 1'b0;
      end else if (do_swap) begin
         swap_pending <= 1'b0;
         front_sel    <= !front_sel;
      end else if (ctrl_swap) begin
         swap_pending <= 1'b1;
      end
   end
`else
   logic unused_swap;
   assign unused_swap  = ctrl_swap;
   assign swap_pending = 1'b0;
   assign front_sel    = 1'b0;
`endif
endmodule

// File: tb/tb_framebuffer.sv
// tb_framebuffer: directed checks of writes, scanout handshake, reset abort and buffer swap
// on an 8x4 framebuffer; honours FB_DOUBLE_BUFFER_EN like the design.
`timescale 1ns/1ps
module tb_framebuffer;
   localparam int W = 8, H = 4, N = W * H;
`ifdef FB_DOUBLE_BUFFER_EN
   localparam bit DB = 1'b1;
`else
   localparam bit DB = 1'b0;
`endif
   logic        clk = 1'b0, reset = 1'b1;
   logic [3:0]  fb_x = '0;
   logic [2:0]  fb_y = '0;
   logic [15:0] fb_color = '0;
   logic        fb_write = 1'b0, frame_start = 1'b0, out_ready = 1'b0, ctrl_swap = 1'b0;
   logic [15:0] out_pixel;
   logic        out_valid, out_last, frame_done, scan_busy, swap_pending, front_sel;
   logic [15:0] model [2][N];
   logic        tb_front = 1'b0;
   int          tests = 0, fails = 0;

   always #5 clk = ~clk;

   framebuffer #(.FB_WIDTH(W), .FB_HEIGHT(H)) dut (
      .clk(clk), .reset(reset), .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color),
      .fb_write(fb_write), .frame_start(frame_start), .out_pixel(out_pixel),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .frame_done(frame_done), .scan_busy(scan_busy), .ctrl_swap(ctrl_swap),
      .swap_pending(swap_pending), .front_sel(front_sel)
   );

   task automatic wr(input int x, input int y, input logic [15:0] c);
      int b;
      b = (DB && !tb_front) ? 1 : 0;
      @(negedge clk);
      fb_x = 4'(x); fb_y = 3'(y); fb_color = c; fb_write = 1'b1;
      if (x < W && y < H) model[b][y*W+x] = c;
   endtask

   task automatic wr_end;
      @(negedge clk);
      fb_write = 1'b0;
   endtask

   task automatic run_frame(input int mode);
      int bank, idx, last_k;
      logic held, r;
      logic [16:0] hp;
      bank = (DB && tb_front) ? 1 : 0;
      idx = 0; last_k = -1; held = 1'b0; hp = '0;
      @(negedge clk);
      frame_start = 1'b1; out_ready = 1'b0;
      for (int k = 1; k < 40 * N; k++) begin
         @(negedge clk);
         frame_start = 1'b0;
         if (k == 1) begin
            tests++;
            if ({out_valid, scan_busy} !== 2'b01) begin fails++; $display("FAIL frame_k1 mode%0d: valid,busy=%b expected 01", mode, {out_valid, scan_busy}); end
         end
         if (k == 2) begin
            tests++;
            if (out_valid !== 1'b1) begin fails++; $display("FAIL first_valid mode%0d: out_valid=%b expected 1", mode, out_valid); end
         end
         if (held) begin
            tests++;
            if (out_valid !== 1'b1 || {out_last, out_pixel} !== hp) begin fails++; $display("FAIL stall_hold mode%0d px%0d: valid=%b last,pix=%h expected 1 %h", mode, idx, out_valid, {out_last, out_pixel}, hp); end
         end
         if (last_k > 0 && k == last_k + 1) begin
            tests++;
            if ({frame_done, scan_busy, out_valid} !== 3'b110) begin fails++; $display("FAIL done_pulse mode%0d: done,busy,valid=%b expected 110", mode, {frame_done, scan_busy, out_valid}); end
         end
         if (last_k > 0 && k == last_k + 2) begin
            tests++;
            if ({frame_done, scan_busy, out_valid} !== 3'b000) begin fails++; $display("FAIL done_end mode%0d: done,busy,valid=%b expected 000", mode, {frame_done, scan_busy, out_valid}); end
            break;
         end
         r = (mode == 0) ? 1'b1 : (mode == 1) ? k[0] : 1'($urandom_range(0, 1));
         out_ready = r;
         held = out_valid && !r;
         hp = {out_last, out_pixel};
         if (out_valid && r) begin
            tests++;
            if (idx >= N) begin fails++; $display("FAIL extra_pixel mode%0d: pixel %0d beyond frame", mode, idx); end
            else if (out_pixel !== model[bank][idx] || out_last !== (idx == N - 1)) begin
               fails++; $display("FAIL pixel mode%0d idx%0d: pix=%h last=%b expected %h %b", mode, idx, out_pixel, out_last, model[bank][idx], idx == N - 1);
            end
            if (idx == N - 1) last_k = k;
            idx++;
         end
      end
      out_ready = 1'b0;
      tests++;
      if (idx != N || last_k < 0) begin fails++; $display("FAIL frame_count mode%0d: %0d pixels expected %0d", mode, idx, N); end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      tests++;
      if ({out_valid, out_last, frame_done, scan_busy, swap_pending, front_sel} !== 6'b0) begin
         fails++; $display("FAIL reset_state: got %b expected 000000", {out_valid, out_last, frame_done, scan_busy, swap_pending, front_sel});
      end
      reset = 1'b0;
   endtask

   task automatic fill;
      for (int i = 0; i < N; i++) wr(i % W, i / W, 16'hC000 + 16'(i * 3));
      wr_end;
      if (DB) begin
         @(negedge clk) ctrl_swap = 1'b1;
         @(negedge clk) ctrl_swap = 1'b0;
         tests++;
         if (swap_pending !== 1'b1) begin fails++; $display("FAIL init_pending: %b expected 1", swap_pending); end
         @(negedge clk);
         tests++;
         if ({swap_pending, front_sel} !== 2'b01) begin fails++; $display("FAIL init_swap: pending,front=%b expected 01", {swap_pending, front_sel}); end
         tb_front = 1'b1;
         for (int i = 0; i < N; i++) wr(i % W, i / W, 16'hC000 + 16'(i * 3));
         wr_end;
      end
   endtask

   task automatic test_write_scan;
      wr(3, 2, 16'hABCD);
      wr_end;
      run_frame(0);
   endtask

   task automatic test_oob;
      wr(8, 0, 16'h1234);
      wr(0, 4, 16'h5678);
      wr_end;
      run_frame(0);
   endtask

   task automatic test_stall;
      run_frame(1);
      run_frame(2);
   endtask

   task automatic test_start_in_scan;
      int bank, wb, cnt, dones;
      logic [15:0] old5;
      bank = (DB && tb_front) ? 1 : 0;
      wb = (DB && !tb_front) ? 1 : 0;
      cnt = 0; dones = 0;
      old5 = model[bank][5];
      @(negedge clk);
      frame_start = 1'b1; out_ready = 1'b1;
      for (int k = 1; k < 4 * N; k++) begin
         @(negedge clk);
         frame_start = (k == 10);
         fb_write = (k == 5);
         if (k == 5) begin fb_x = 4'd5; fb_y = 3'd0; fb_color = ~old5; model[wb][5] = ~old5; end
         if (frame_done) dones++;
         if (out_valid) begin
            tests++;
            if (cnt >= N) begin fails++; $display("FAIL restart_pixel: pixel %0d beyond frame", cnt); end
            else if (out_pixel !== ((cnt == 5) ? old5 : model[bank][cnt])) begin
               fails++; $display("FAIL read_first idx%0d: pix=%h expected %h", cnt, out_pixel, (cnt == 5) ? old5 : model[bank][cnt]);
            end
            cnt++;
         end
      end
      out_ready = 1'b0;
      tests++;
      if (cnt != N || dones != 1) begin fails++; $display("FAIL single_frame: %0d pixels %0d done pulses expected %0d 1", cnt, dones, N); end
   endtask

   task automatic test_reset_mid;
      int cnt, bad;
      cnt = 0; bad = 0;
      @(negedge clk);
      frame_start = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      for (int k = 0; k < 100 && cnt < 10; k++) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      reset = 1'b1;
      @(negedge clk);
      tests++;
      if ({out_valid, scan_busy, frame_done, front_sel} !== 4'b0) begin
         fails++; $display("FAIL reset_abort: valid,busy,done,front=%b expected 0000", {out_valid, scan_busy, frame_done, front_sel});
      end
      reset = 1'b0;
      tb_front = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (frame_done || out_valid) bad++;
      end
      tests++;
      if (bad != 0) begin fails++; $display("FAIL reset_quiet: %0d active cycles expected 0", bad); end
      out_ready = 1'b0;
      run_frame(0);
   endtask

   task automatic test_swap;
      if (!DB) begin
         @(negedge clk) ctrl_swap = 1'b1;
         @(negedge clk) ctrl_swap = 1'b0;
         @(negedge clk);
         tests++;
         if ({swap_pending, front_sel} !== 2'b00) begin fails++; $display("FAIL swap_ignored: pending,front=%b expected 00", {swap_pending, front_sel}); end
      end else begin
         logic old;
         old = tb_front;
         fork
            run_frame(1);
            begin
               int bad, seen;
               bad = 0; seen = 0;
               for (int i = 0; i < N; i++) begin
                  wr(i % W, i / W, 16'h0001);
                  ctrl_swap = (i == 5 || i == 7);
                  if (i > 6 && swap_pending !== 1'b1) bad++;
               end
               wr_end;
               ctrl_swap = 1'b0;
               for (int k = 0; k < 40 * N && seen == 0; k++) begin
                  @(negedge clk);
                  if (frame_done) seen = 1;
                  else if (swap_pending !== 1'b1 || front_sel !== old) bad++;
               end
               tests++;
               if (seen == 0 || bad != 0 || swap_pending !== 1'b1 || front_sel !== old) begin
                  fails++; $display("FAIL swap_midframe: seen=%0d bad=%0d pending=%b front=%b expected 1 0 1 %b", seen, bad, swap_pending, front_sel, old);
               end
               @(negedge clk);
               tests++;
               if ({swap_pending, front_sel} !== {1'b0, !old}) begin fails++; $display("FAIL swap_after: pending,front=%b expected 0%b", {swap_pending, front_sel}, !old); end
            end
         join
         tb_front = !old;
         run_frame(0);
      end
   endtask

   initial begin
      test_reset;
      fill;
      test_write_scan;
      test_oob;
      test_stall;
      test_start_in_scan;
      test_reset_mid;
      test_swap;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
